// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constants for the debounce/stepper block
// Contents:
//   deb_state_t  : debounce channel FSM state (STABLE / COUNTING)
//   hold_state_t : long-hold FSM state on channel 0 (IDLE / TIMING / FIRED)
//   SEG_HEX      : hex digit to 7-segment {g,f,e,d,c,b,a}, active high
package debounce_pkg;

  typedef enum logic {
    DEB_STABLE   = 1'b0,
    DEB_COUNTING = 1'b1
  } deb_state_t;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_TIMING = 2'd1,
    H_FIRED  = 2'd2
  } hold_state_t;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one button channel: 2-flop synchroniser plus debouncer
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   button     : raw asynchronous input, 1 = pressed
//   level      : debounced level
//   press      : 1-cycle pulse on debounced 0->1
//   rel        : 1-cycle pulse on debounced 1->0
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a, sync_b;
  deb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, press_nxt, rel_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      state  <= DEB_STABLE;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_a <= button;
      sync_b <= sync_a;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      press  <= press_nxt;
      rel    <= rel_nxt;
    end
  end

  // The counter counts cycles where the synchronised input disagrees with the
  // debounced level; any agreement in between restarts the qualification.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      DEB_STABLE: begin
        if (sync_b != level) begin
          state_nxt = DEB_COUNTING;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      DEB_COUNTING: begin
        if (sync_b == level) begin
          state_nxt = DEB_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          level_nxt = sync_b;
          press_nxt = sync_b;
          rel_nxt   = ~sync_b;
          state_nxt = DEB_STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = DEB_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/debounce_stepper.sv
// rtl/debounce_stepper.sv - debounced buttons driving a modulo step counter and 7-seg digit
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   button       : raw button inputs, 1 = pressed (btn0 = up, btn1 = down)
//   btn_level    : debounced levels
//   btn_press    : 1-cycle pulses on debounced press
//   btn_release  : 1-cycle pulses on debounced release
//   step         : current step, 0..NUM_STEPS-1
//   step_wrap    : 1-cycle pulse when step wraps in either direction
//   long_hold    : 1-cycle pulse when btn0 has been held HOLD_CYCLES after its press
//   seg          : {g,f,e,d,c,b,a} hex digit of step, active high
module debounce_stepper
  import debounce_pkg::*;
#(
  parameter int NUM_BTN     = 2,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int NUM_STEPS   = 3,
  parameter int STEP_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_BTN-1:0] button,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [STEP_W-1:0] step,
  output logic              step_wrap,
  output logic              long_hold,
  output logic [6:0]        seg
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_chan #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .button(button[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end

  hold_state_t       hstate, hstate_nxt;
  logic [HW-1:0]     hcnt, hcnt_nxt;
  logic              hold_fire;
  logic [STEP_W-1:0] step_nxt;
  logic              wrap_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hstate    <= H_IDLE;
      hcnt      <= '0;
      step      <= '0;
      step_wrap <= 1'b0;
      long_hold <= 1'b0;
      seg       <= SEG_HEX[0];
    end else begin
      hstate    <= hstate_nxt;
      hcnt      <= hcnt_nxt;
      step      <= step_nxt;
      step_wrap <= wrap_nxt;
      long_hold <= hold_fire;
      seg       <= SEG_HEX[step_nxt];
    end
  end

  // H_FIRED parks the FSM until the button is let go, so one press can
  // produce at most one long_hold.
  always_comb begin
    hstate_nxt = hstate;
    hcnt_nxt   = hcnt;
    hold_fire  = 1'b0;
    case (hstate)
      H_IDLE: begin
        if (btn_press[0]) begin
          hstate_nxt = H_TIMING;
          hcnt_nxt   = '0;
        end
      end
      H_TIMING: begin
        if (!btn_level[0]) begin
          hstate_nxt = H_IDLE;
        end else if (hcnt == HOLD_LAST) begin
          hold_fire  = 1'b1;
          hstate_nxt = H_FIRED;
        end else begin
          hcnt_nxt = hcnt + HW'(1);
        end
      end
      H_FIRED: begin
        if (!btn_level[0]) hstate_nxt = H_IDLE;
      end
      default: hstate_nxt = H_IDLE;
    endcase
  end

  // Long hold wins over any down press in the same cycle; simultaneous
  // up and down presses cancel out.
  always_comb begin
    step_nxt = step;
    wrap_nxt = 1'b0;
    if (hold_fire) begin
      step_nxt = '0;
    end else if (btn_press[0] && btn_press[1]) begin
      step_nxt = step;
    end else if (btn_press[0]) begin
      if (step == STEP_LAST) begin
        step_nxt = '0;
        wrap_nxt = 1'b1;
      end else begin
        step_nxt = step + STEP_W'(1);
      end
    end else if (btn_press[1]) begin
      if (step == '0) begin
        step_nxt = STEP_LAST;
        wrap_nxt = 1'b1;
      end else begin
        step_nxt = step - STEP_W'(1);
      end
    end
  end

endmodule
